debounce_edge: RTL and testbench
================================

Name: debounce_edge

Overview:
- Input conditioning stage that sits directly upstream of the DFF stage and drives its D input.
- Takes a raw, asynchronous, possibly bouncing signal (button, switch, external line).
- Synchronizes it, then debounces it with a stability counter and state machine.
- Outputs a clean registered level plus single-cycle rise/fall strobes for downstream registers.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the synchronizer chain; legal range 2..4.
- CNT_W, 16, width of the stability counter.
- STABLE_CYCLES, 1000, consecutive equal synchronized samples required to accept a new level; legal range 2..2^CNT_W-1.
- RESET_LEVEL, 0, value loaded into the sync chain and dout on reset.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- din  input  1  raw asynchronous input; may glitch at any time.
- dout  output  1  debounced level, registered.
- rise  output  1  one-cycle pulse, high on the same cycle dout goes 0->1.
- fall  output  1  one-cycle pulse, high on the same cycle dout goes 1->0.
- busy  output  1  high while a candidate level change is being qualified (CHECK states).

Behaviour:
- Interface (decided): one clock; reset is synchronous and active-high. Ports are clk and rst.
- Synchronizer:
  - SYNC_STAGES-deep shift register; s denotes the last stage.
  - din is first visible on s after SYNC_STAGES edges.
  - No logic other than the next stage may read stage 0.
- FSM states: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO. Counter cnt is CNT_W bits.
- STABLE_LO:
  - s=1 -> CHECK_HI, cnt<=1.
  - Otherwise hold, cnt<=0.
- CHECK_HI:
  - s=0 -> STABLE_LO, cnt<=0. Glitch is rejected; no pulse is produced.
  - s=1 and cnt==STABLE_CYCLES-1 -> STABLE_HI, dout<=1, rise<=1.
  - Otherwise cnt<=cnt+1.
- STABLE_HI and CHECK_LO mirror the above with polarities swapped; fall replaces rise.
- Latency and registering:
  - dout changes on the edge at which s has been sampled at the new value on STABLE_CYCLES consecutive edges.
  - Total latency from a clean din step to dout is SYNC_STAGES+STABLE_CYCLES edges, ±1 for input sampling phase.
- rise and fall are registered and high for exactly one cycle. They are never both high, and are never high without a coincident dout change.
- busy = (state==CHECK_HI || state==CHECK_LO), registered via state.
- Counter: cnt never exceeds STABLE_CYCLES-1, so it never wraps. A compile-time check fails if STABLE_CYCLES > 2^CNT_W-1 or STABLE_CYCLES < 2.
- Reset (synchronous, highest priority, wins over any transition):
  - Sync chain, dout <= RESET_LEVEL.
  - state <= STABLE_HI if RESET_LEVEL else STABLE_LO.
  - cnt <= 0; rise, fall, busy <= 0.
  - Reset asserted mid-CHECK aborts the qualification; no pulse is emitted, including on the reset-release cycle.
- After reset release: if s differs from RESET_LEVEL, a normal CHECK qualification starts. There is no implicit edge at release.
- Simultaneous events: an s toggle on the terminal-count edge (cnt==STABLE_CYCLES-1 with s reverting) counts as a glitch. The FSM returns to the STABLE state and no dout change occurs.

Decomposition:
- Package debounce_pkg holds:
  - state encoding constants ST_STABLE_LO=2'b00, ST_CHECK_HI=2'b01, ST_STABLE_HI=2'b11, ST_CHECK_LO=2'b10.
  - The parameter-legality check helper.
- Sub-module sync_chain (params STAGES, INIT; ports clk, rst, d, q): a plain DFF shift register with synchronous reset to INIT. The debounce FSM and counter live in debounce_edge.

Test Plan (STABLE_CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=0, clk period 20):
- Reset hold: rst=1 for 3 cycles with din toggling every 13 time units -> dout=0, rise=0, fall=0, busy=0 throughout reset.
- Clean rise: din 0->1 and held -> s=1 after 2 edges, busy high 3 cycles, dout=1 and rise=1 for exactly 1 cycle at edge 2+4 after the step; fall stays 0.
- Glitch rejection: din pulses high for 2 cycles then returns to 0 -> busy pulses, dout stays 0, no rise. Repeat with a 3-sample high (one short of 4) -> still no rise.
- Clean fall: from dout=1, din 1->0 held -> fall=1 for one cycle and dout=0 at 2+4 edges after the step.
- Reset mid-qualification: din 0->1, rst=1 asserted while busy=1 (cnt=2), released 1 cycle later with din still 1 -> no rise during or at release. The qualification restarts and rise fires 4 edges after s is next sampled 1.
- Bounce burst: din toggles every cycle for 10 cycles then settles at 1 -> dout and rise change exactly once, after 4 stable samples; total rise count = 1.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce stage.
// State codes and the parameter legality check.
package debounce_pkg;

  localparam logic [1:0] ST_STABLE_LO = 2'b00;
  localparam logic [1:0] ST_CHECK_HI  = 2'b01;
  localparam logic [1:0] ST_STABLE_HI = 2'b11;
  localparam logic [1:0] ST_CHECK_LO  = 2'b10;

  function automatic bit cfg_ok(
    input int     stages,
    input int     cnt_w,
    input longint stable
  );
    longint max_cnt;
    max_cnt = (longint'(1) << cnt_w) - 1;
    return (stages >= 2) && (stages <= 4) &&
           (cnt_w >= 1) && (cnt_w <= 32) &&
           (stable >= 2) && (stable <= max_cnt);
  endfunction

endpackage

// File: rtl/debounce_edge_sync.sv
// Plain DFF shift register bringing an async line into clk.
// Synchronous reset loads every stage with INIT.
module sync_chain #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= {STAGES{INIT}};
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronize + debounce a raw line; emit a clean level
// and one-cycle rise/fall strobes.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int          SYNC_STAGES   = 2,
  parameter int          CNT_W         = 16,
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (!cfg_ok(SYNC_STAGES, CNT_W, longint'(STABLE_CYCLES))) begin : g_bad_cfg
    $error("debounce_edge: illegal parameter set");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0] ST_RESET =
    RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;

  logic             s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_chain #(
    .STAGES (SYNC_STAGES),
    .INIT   (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      dout_q  <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // A reverting sample always wins over the terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_STABLE_LO: begin
        if (s) begin
          state_d = ST_CHECK_HI;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_CHECK_HI: begin
        if (!s) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE_HI: begin
        if (!s) begin
          state_d = ST_CHECK_LO;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_CHECK_LO: begin
        if (s) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == ST_CHECK_HI) ||
           (state_q == ST_CHECK_LO);
    dout = dout_q;
    rise = rise_q;
    fall = fall_q;
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge with
// STABLE_CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=0.
module tb_debounce_edge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout, rise, fall, busy;

  int checks   = 0;
  int failures = 0;

  debounce_edge #(
    .SYNC_STAGES   (2),
    .CNT_W         (16),
    .STABLE_CYCLES (4),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst = 1'b1;
    fork
      begin
        repeat (4) begin
          #13;
          din = ~din;
        end
      end
      begin
        for (int c = 1; c <= 3; c++) begin
          tick();
          got = {dout, rise, fall, busy};
          checks++;
          if (got !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got=%b exp=0000",
                     c, got);
          end
        end
      end
    join
    din = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      got = {dout, rise, fall, busy};
      checks++;
      if (got !== 4'b0000) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got=%b exp=0000",
                 c, got);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] got, exp;
    for (int len = 2; len <= 3; len++) begin
      din = 1'b1;
      for (int e = 1; e <= 10; e++) begin
        tick();
        if (e == len) din = 1'b0;
        exp = {3'b000, (e >= 3 && e <= len + 2)};
        got = {dout, rise, fall, busy};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL glitch len=%0d cyc=%0d got=%b exp=%b",
                   len, e, got, exp);
        end
      end
    end
  endtask

  task automatic test_clean_rise();
    logic [3:0] got, exp;
    din = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = {(e >= 6), (e == 6), 1'b0, (e >= 3 && e <= 5)};
      got = {dout, rise, fall, busy};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL clean_rise cyc=%0d got=%b exp=%b",
                 e, got, exp);
      end
    end
  endtask

  task automatic test_clean_fall();
    logic [3:0] got, exp;
    din = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = {(e < 6), 1'b0, (e == 6), (e >= 3 && e <= 5)};
      got = {dout, rise, fall, busy};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL clean_fall cyc=%0d got=%b exp=%b",
                 e, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_check();
    logic [3:0] got, exp;
    din = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      exp = {3'b000, (e >= 3)};
      got = {dout, rise, fall, busy};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL abort_pre cyc=%0d got=%b exp=%b",
                 e, got, exp);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {dout, rise, fall, busy};
    checks++;
    if (got !== 4'b0000) begin
      failures++;
      $display("FAIL abort_rst got=%b exp=0000", got);
    end
    // Chain was cleared, so requalification starts from scratch.
    for (int r = 1; r <= 8; r++) begin
      tick();
      exp = {(r >= 6), (r == 6), 1'b0, (r >= 3 && r <= 5)};
      got = {dout, rise, fall, busy};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL abort_restart cyc=%0d got=%b exp=%b",
                 r, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] got, exp;
    int rises;
    int falls;
    din = 1'b0;
    repeat (8) tick();
    checks++;
    if (dout !== 1'b0) begin
      failures++;
      $display("FAIL bounce_prep got=%b exp=0", dout);
    end
    rises = 0;
    falls = 0;
    for (int k = 1; k <= 20; k++) begin
      din = (k > 10) ? 1'b1 : logic'(k % 2);
      tick();
      rises += int'(rise);
      falls += int'(fall);
      exp = {(k >= 16), (k == 16), 1'b0};
      got = {dout, rise, fall};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL bounce cyc=%0d got=%b exp=%b",
                 k, got, exp);
      end
    end
    checks++;
    if (rises != 1 || falls != 0) begin
      failures++;
      $display("FAIL bounce_count rises=%0d falls=%0d exp=1/0",
               rises, falls);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_rise();
    test_clean_fall();
    test_reset_mid_check();
    test_bounce();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
